// File: rtl/alu_rr_arbiter.sv
// Round-robin front end sharing one combinational ALU between two requesters.
// One operation in flight: accept (IDLE) -> drive ALU (EXEC) -> hold result (RESP).
module alu_rr_arbiter #(
   parameter int unsigned W = 4
) (
   input  logic         clk,
   input  logic         rst,
   input  logic         req0_valid,
   output logic         req0_ready,
   input  logic [W-1:0] req0_a,
   input  logic [W-1:0] req0_b,
   input  logic [2:0]   req0_sel,
   input  logic         req1_valid,
   output logic         req1_ready,
   input  logic [W-1:0] req1_a,
   input  logic [W-1:0] req1_b,
   input  logic [2:0]   req1_sel,
   output logic         resp0_valid,
   input  logic         resp0_ready,
   output logic         resp1_valid,
   input  logic         resp1_ready,
   output logic [W-1:0] resp_data,
   output logic         resp_cf,
   output logic         resp_of,
   output logic         resp_zf,
   output logic [W-1:0] alu_a,
   output logic [W-1:0] alu_b,
   output logic [2:0]   alu_sel,
   input  logic [W-1:0] alu_out,
   input  logic         alu_cf,
   input  logic         alu_of,
   input  logic         alu_zf,
   output logic         busy
);

   typedef enum logic [1:0] {IDLE, EXEC, RESP} state_t;

   state_t state, state_nx;
   logic   ptr;
   logic   owner;
   logic   fire0, fire1;
   logic   done;

   always_comb begin
      // Pointer only breaks ties; a lone requester is always ready in IDLE.
      req0_ready  = (state == IDLE) & ~rst & (~ptr | ~req1_valid);
      req1_ready  = (state == IDLE) & ~rst & (ptr | ~req0_valid);
      fire0       = req0_valid & req0_ready;
      fire1       = req1_valid & req1_ready;
      resp0_valid = (state == RESP) & ~owner;
      resp1_valid = (state == RESP) & owner;
      done        = (state == RESP) & (owner ? resp1_ready : resp0_ready);
      busy        = (state != IDLE);
      state_nx    = state;
      case (state)
         IDLE:    if (fire0 | fire1) state_nx = EXEC;
         EXEC:    state_nx = RESP;
         RESP:    if (done) state_nx = IDLE;
         default: state_nx = IDLE;
      endcase
   end

   always_ff @(posedge clk) begin
      if (rst) begin
         state     <= IDLE;
         ptr       <= 1'b0;
         owner     <= 1'b0;
         alu_a     <= '0;
         alu_b     <= '0;
         alu_sel   <= '0;
         resp_data <= '0;
         resp_cf   <= 1'b0;
         resp_of   <= 1'b0;
         resp_zf   <= 1'b0;
      end else begin
         state <= state_nx;
         if (fire0) begin
            alu_a   <= req0_a;
            alu_b   <= req0_b;
            alu_sel <= req0_sel;
            owner   <= 1'b0;
            ptr     <= 1'b1;
         end else if (fire1) begin
            alu_a   <= req1_a;
            alu_b   <= req1_b;
            alu_sel <= req1_sel;
            owner   <= 1'b1;
            ptr     <= 1'b0;
         end
         if (state == EXEC) begin
            // The ALU leaves cf/of stale for non-arithmetic ops, so mask them here.
            resp_data <= alu_out;
            resp_zf   <= alu_zf;
            resp_cf   <= (alu_sel[2:1] == 2'b00) ? alu_cf : 1'b0;
            resp_of   <= (alu_sel[2:1] == 2'b00) ? alu_of : 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_alu_rr_arbiter.sv
// Self-checking bench for alu_rr_arbiter: directed scenarios plus randomized traffic
// against a transaction-level reference model; also hosts a behavioural ALU.
module tb_alu_rr_arbiter;
   localparam int unsigned W = 4;

   logic         clk = 1'b0;
   logic         rst = 1'b1;
   logic         req0_valid = 1'b0, req1_valid = 1'b0;
   logic         req0_ready, req1_ready;
   logic [W-1:0] req0_a = '0, req0_b = '0, req1_a = '0, req1_b = '0;
   logic [2:0]   req0_sel = '0, req1_sel = '0;
   logic         resp0_valid, resp1_valid;
   logic         resp0_ready = 1'b0, resp1_ready = 1'b0;
   logic [W-1:0] resp_data;
   logic         resp_cf, resp_of, resp_zf;
   logic [W-1:0] alu_a, alu_b, alu_out;
   logic [2:0]   alu_sel;
   logic         alu_cf, alu_of, alu_zf;
   logic         busy;

   int passed = 0;
   int total  = 0;

   always #5 clk = ~clk;

   alu_rr_arbiter #(.W(W)) dut (
      .clk(clk), .rst(rst),
      .req0_valid(req0_valid), .req0_ready(req0_ready), .req0_a(req0_a), .req0_b(req0_b), .req0_sel(req0_sel),
      .req1_valid(req1_valid), .req1_ready(req1_ready), .req1_a(req1_a), .req1_b(req1_b), .req1_sel(req1_sel),
      .resp0_valid(resp0_valid), .resp0_ready(resp0_ready),
      .resp1_valid(resp1_valid), .resp1_ready(resp1_ready),
      .resp_data(resp_data), .resp_cf(resp_cf), .resp_of(resp_of), .resp_zf(resp_zf),
      .alu_a(alu_a), .alu_b(alu_b), .alu_sel(alu_sel),
      .alu_out(alu_out), .alu_cf(alu_cf), .alu_of(alu_of), .alu_zf(alu_zf),
      .busy(busy)
   );

   // Behavioural ALU; cf/of driven to 1 on non-arithmetic ops to expose missing masking.
   always_comb begin
      logic [W:0] t;
      t      = '0;
      alu_cf = 1'b1;
      alu_of = 1'b1;
      case (alu_sel)
         3'd0: begin
            t = {1'b0, alu_a} + {1'b0, alu_b};
            alu_out = t[W-1:0];
            alu_cf = t[W];
            alu_of = (alu_a[W-1] == alu_b[W-1]) && (alu_out[W-1] != alu_a[W-1]);
         end
         3'd1: begin
            t = {1'b0, alu_a} - {1'b0, alu_b};
            alu_out = t[W-1:0];
            alu_cf = t[W];
            alu_of = (alu_a[W-1] != alu_b[W-1]) && (alu_out[W-1] != alu_a[W-1]);
         end
         3'd2:    alu_out = ~alu_a;
         3'd3:    alu_out = alu_a & alu_b;
         3'd4:    alu_out = alu_a | alu_b;
         3'd5:    alu_out = alu_a ^ alu_b;
         3'd6:    alu_out = (alu_a < alu_b) ? W'(1) : W'(0);
         default: alu_out = (alu_a == alu_b) ? W'(1) : W'(0);
      endcase
      alu_zf = (alu_out == '0);
   end

   // Expected {cf, of, zf, data} from plain integer arithmetic.
   function automatic logic [6:0] ref_op(input logic [3:0] a, input logic [3:0] b, input logic [2:0] s);
      int ua, ub, sa, sb, r, sr, d;
      logic c, o;
      ua = int'(a); ub = int'(b);
      sa = (ua > 7) ? ua - 16 : ua;
      sb = (ub > 7) ? ub - 16 : ub;
      c = 1'b0; o = 1'b0; d = 0;
      case (s)
         3'd0: begin r = ua + ub; d = r % 16; c = (r > 15); sr = sa + sb; o = (sr > 7) || (sr < -8); end
         3'd1: begin r = ua - ub; d = (r + 16) % 16; c = (ua < ub); sr = sa - sb; o = (sr > 7) || (sr < -8); end
         3'd2: d = 15 - ua;
         3'd3: d = int'(a & b);
         3'd4: d = int'(a | b);
         3'd5: d = int'(a ^ b);
         3'd6: d = (ua < ub) ? 1 : 0;
         default: d = (ua == ub) ? 1 : 0;
      endcase
      ref_op = {c, o, (d == 0), 4'(d)};
   endfunction

   // Transaction-level reference: timestamps of accept, not a state encoding.
   logic       m_inflight = 1'b0, m_ptr = 1'b0, m_owner = 1'b0;
   int         m_cyc = 0, m_acc = 0;
   logic [3:0] m_a = '0, m_b = '0;
   logic [2:0] m_sel = '0;
   logic [6:0] m_res = '0;

   function automatic logic exp_ready(input logic n);
      exp_ready = !rst && !m_inflight && (m_ptr == n || !(n ? req0_valid : req1_valid));
   endfunction

   always @(posedge clk) begin
      if (rst) begin
         m_inflight = 1'b0; m_ptr = 1'b0; m_owner = 1'b0;
         m_a = '0; m_b = '0; m_sel = '0; m_res = '0;
      end else if (m_inflight) begin
         if (m_cyc == m_acc + 1) m_res = ref_op(m_a, m_b, m_sel);
         else if (m_owner ? resp1_ready : resp0_ready) m_inflight = 1'b0;
      end else if (req0_valid && exp_ready(1'b0)) begin
         m_inflight = 1'b1; m_acc = m_cyc; m_owner = 1'b0; m_ptr = 1'b1;
         m_a = req0_a; m_b = req0_b; m_sel = req0_sel;
      end else if (req1_valid && exp_ready(1'b1)) begin
         m_inflight = 1'b1; m_acc = m_cyc; m_owner = 1'b1; m_ptr = 1'b0;
         m_a = req1_a; m_b = req1_b; m_sel = req1_sel;
      end
      m_cyc++;
   end

   task automatic do_reset();
      @(negedge clk);
      rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0;
      @(negedge clk);
      rst = 1'b0;
   endtask

   // Issues one op on requester n and waits (bounded) for its response; lat=-1 if never seen.
   task automatic run_op(input logic n, input logic [3:0] a, input logic [3:0] b, input logic [2:0] s,
                         output logic [6:0] got, output int lat);
      int i;
      lat = -1; got = '0;
      @(negedge clk);
      resp0_ready = 1'b1; resp1_ready = 1'b1;
      if (n) begin req1_valid = 1'b1; req1_a = a; req1_b = b; req1_sel = s; end
      else   begin req0_valid = 1'b1; req0_a = a; req0_b = b; req0_sel = s; end
      #1;
      i = 0;
      while (!(n ? req1_ready : req0_ready) && i < 5) begin @(negedge clk); #1; i++; end
      if (i >= 5) begin req0_valid = 1'b0; req1_valid = 1'b0; return; end
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      #1;
      for (int k = 1; k <= 5 && lat < 0; k++) begin
         if (n ? resp1_valid : resp0_valid) begin
            lat = k; got = {resp_cf, resp_of, resp_zf, resp_data};
         end else begin
            @(negedge clk); #1;
         end
      end
   endtask

   task automatic test_reset();
      rst = 1'b1; req0_valid = 1'b1; req1_valid = 1'b1;
      for (int c = 0; c < 2; c++) begin
         @(negedge clk); #1;
         total++;
         if ({req0_ready, req1_ready, resp0_valid, resp1_valid, busy, resp_data, resp_cf, resp_of, resp_zf,
              alu_a, alu_b, alu_sel} !== '0)
            $display("FAIL reset_outputs: rdy=%b%b rv=%b%b busy=%b data=%h alu=%h/%h/%h, required all 0",
                     req0_ready, req1_ready, resp0_valid, resp1_valid, busy, resp_data, alu_a, alu_b, alu_sel);
         else passed++;
      end
      @(negedge clk);
      rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   task automatic test_single_add();
      logic [6:0] got; int lat;
      run_op(1'b0, 4'd3, 4'd4, 3'd0, got, lat);
      total++;
      if (lat !== 2) $display("FAIL add_latency: got %0d required 2", lat); else passed++;
      total++;
      if (got !== 7'b000_0111) $display("FAIL add_result: got cf/of/zf/data=%b required 0000111", got);
      else passed++;
   endtask

   task automatic test_alternate();
      do_reset();
      resp0_ready = 1'b1; resp1_ready = 1'b1;
      req0_a = 4'd1; req0_b = 4'd2; req0_sel = 3'd0;
      req1_a = 4'd9; req1_b = 4'd3; req1_sel = 3'd2;
      for (int g = 0; g < 4; g++) begin
         @(negedge clk);
         req0_valid = 1'b1; req1_valid = 1'b1;
         #1;
         total++;
         if ({req0_ready, req1_ready} !== ((g % 2 == 0) ? 2'b10 : 2'b01))
            $display("FAIL alt_grant%0d: ready=%b%b required %b", g, req0_ready, req1_ready,
                     (g % 2 == 0) ? 2'b10 : 2'b01);
         else passed++;
         @(negedge clk); #1;
         total++;
         if ({busy, req0_ready, req1_ready} !== 3'b100)
            $display("FAIL alt_exec%0d: busy/ready=%b required 100", g, {busy, req0_ready, req1_ready});
         else passed++;
         @(negedge clk); #1;
         total++;
         if ({resp0_valid, resp1_valid, resp_data} !== ((g % 2 == 0) ? {2'b10, 4'd3} : {2'b01, 4'd6}))
            $display("FAIL alt_resp%0d: valid=%b%b data=%h", g, resp0_valid, resp1_valid, resp_data);
         else passed++;
      end
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_flags();
      logic [6:0] got; int lat;
      run_op(1'b1, 4'd15, 4'd1, 3'd0, got, lat);
      total++;
      if (lat !== 2 || got !== 7'b101_0000) $display("FAIL flags_carry: got %b lat %0d required 1010000 lat 2", got, lat);
      else passed++;
      run_op(1'b1, 4'd5, 4'd5, 3'd7, got, lat);
      total++;
      if (lat !== 2 || got !== 7'b000_0001) $display("FAIL flags_eq: got %b lat %0d required 0000001 lat 2", got, lat);
      else passed++;
      run_op(1'b1, 4'd6, 4'd6, 3'd1, got, lat);
      total++;
      if (lat !== 2 || got !== 7'b001_0000) $display("FAIL flags_subzero: got %b lat %0d required 0010000 lat 2", got, lat);
      else passed++;
      run_op(1'b0, 4'd7, 4'd1, 3'd0, got, lat);
      total++;
      if (lat !== 2 || got !== 7'b010_1000) $display("FAIL flags_overflow: got %b lat %0d required 0101000 lat 2", got, lat);
      else passed++;
   endtask

   task automatic test_backpressure();
      @(negedge clk);
      resp0_ready = 1'b0; resp1_ready = 1'b0;
      req0_valid = 1'b1; req0_a = 4'd2; req0_b = 4'd7; req0_sel = 3'd3;
      req1_valid = 1'b0;
      #1;
      total++;
      if (req0_ready !== 1'b1) $display("FAIL bp_accept: ready0=%b required 1", req0_ready); else passed++;
      @(negedge clk);
      req0_valid = 1'b1; req1_valid = 1'b1;
      for (int c = 0; c < 5; c++) begin
         @(negedge clk); #1;
         total++;
         if ({resp0_valid, resp1_valid, resp_data, req0_ready, req1_ready, busy} !== {2'b10, 4'd2, 3'b001})
            $display("FAIL bp_hold%0d: valid=%b%b data=%h ready=%b%b busy=%b required 10/2/00/1",
                     c, resp0_valid, resp1_valid, resp_data, req0_ready, req1_ready, busy);
         else passed++;
      end
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0; resp0_ready = 1'b1;
      @(negedge clk); #1;
      total++;
      if ({busy, resp0_valid} !== 2'b00) $display("FAIL bp_release: busy/valid=%b%b required 00", busy, resp0_valid);
      else passed++;
   endtask

   task automatic test_reset_mid_op();
      logic seen;
      do_reset();
      resp0_ready = 1'b1; resp1_ready = 1'b1;
      @(negedge clk);
      req0_valid = 1'b1; req0_a = 4'd8; req0_b = 4'd8; req0_sel = 3'd0;
      @(negedge clk);
      req0_valid = 1'b0; rst = 1'b1;
      @(negedge clk);
      rst = 1'b0;
      seen = 1'b0;
      for (int c = 0; c < 4; c++) begin
         #1;
         if (resp0_valid || resp1_valid || busy) seen = 1'b1;
         @(negedge clk);
      end
      total++;
      if (seen !== 1'b0) $display("FAIL midop_dropped: response or busy observed=%b required 0", seen); else passed++;
      req0_valid = 1'b1; req1_valid = 1'b1;
      #1;
      total++;
      if ({req0_ready, req1_ready} !== 2'b10) $display("FAIL midop_ptr: ready=%b%b required 10", req0_ready, req1_ready);
      else passed++;
      @(negedge clk);
      req0_valid = 1'b0; req1_valid = 1'b0;
      repeat (3) @(negedge clk);
   endtask

   task automatic test_random();
      do_reset();
      for (int c = 0; c < 400; c++) begin
         @(negedge clk);
         rst         = ($urandom_range(0, 63) == 0);
         req0_valid  = ($urandom_range(0, 9) < 7);
         req1_valid  = ($urandom_range(0, 9) < 7);
         req0_a      = 4'($urandom); req0_b = 4'($urandom); req0_sel = 3'($urandom);
         req1_a      = 4'($urandom); req1_b = 4'($urandom); req1_sel = 3'($urandom);
         resp0_ready = ($urandom_range(0, 9) < 6);
         resp1_ready = ($urandom_range(0, 9) < 6);
         #1;
         total++;
         if ({req0_ready, req1_ready, busy, resp0_valid, resp1_valid} !==
             {exp_ready(1'b0), exp_ready(1'b1), m_inflight,
              m_inflight && (m_cyc >= m_acc + 2) && !m_owner, m_inflight && (m_cyc >= m_acc + 2) && m_owner})
            $display("FAIL rnd_ctrl@%0d: rdy/busy/rv=%b required %b", c,
                     {req0_ready, req1_ready, busy, resp0_valid, resp1_valid},
                     {exp_ready(1'b0), exp_ready(1'b1), m_inflight,
                      m_inflight && (m_cyc >= m_acc + 2) && !m_owner, m_inflight && (m_cyc >= m_acc + 2) && m_owner});
         else passed++;
         total++;
         if ({alu_a, alu_b, alu_sel} !== {m_a, m_b, m_sel})
            $display("FAIL rnd_alu@%0d: a/b/sel=%h/%h/%h required %h/%h/%h", c, alu_a, alu_b, alu_sel, m_a, m_b, m_sel);
         else passed++;
         total++;
         if ({resp_cf, resp_of, resp_zf, resp_data} !== m_res)
            $display("FAIL rnd_resp@%0d: cf/of/zf/data=%b required %b", c,
                     {resp_cf, resp_of, resp_zf, resp_data}, m_res);
         else passed++;
      end
      @(negedge clk);
      rst = 1'b0; req0_valid = 1'b0; req1_valid = 1'b0;
   endtask

   initial begin
      test_reset();
      test_single_add();
      test_alternate();
      test_flags();
      test_backpressure();
      test_reset_mid_op();
      test_random();
      $display("%0d/%0d checks passed", passed, total);
      $finish;
   end

endmodule
